// File: rtl/data_memory_if.sv
// rtl/data_memory_if.sv - core load/store bus and TX byte stream bundle for data_memory
//
// Purpose: groups the data-side bus signals between the core / byte consumer
// (master) and data_memory (slave).
// Signals:
//   mem_write  - store strobe from core
//   addr       - byte address (core alu_result)
//   write_data - store data
//   read_data  - combinational load data
//   tx_data    - byte at TX FIFO head
//   tx_valid   - TX FIFO non-empty
//   tx_ready   - consumer accepts the head byte this cycle
interface data_memory_if;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output mem_write, addr, write_data, tx_ready,
    input  read_data, tx_data, tx_valid
  );

  modport slave (
    input  mem_write, addr, write_data, tx_ready,
    output read_data, tx_data, tx_valid
  );
endinterface

// File: rtl/data_memory.sv
// rtl/data_memory.sv - single-cycle data memory with word RAM and MMIO page (cycle counter, TX FIFO)
//
// Purpose: data-side memory stage for a single-cycle core. Loads are
// combinational from addr; stores commit on the rising clock edge.
//   addr[31:16] == MMIO_BASE[31:16] : MMIO page, register = addr[3:2],
//                                     addr[15:4] != 0 is unmapped
//     0x0 CYCLE  (RO) free-running clock counter
//     0x4 TXDATA (WO) push write_data[7:0] into the TX FIFO
//     0x8 STATUS      {OVF, count, empty, full}; store with OVF bit set clears OVF
//     0xC             reads 0, writes ignored
//   otherwise        : word RAM, index addr[WORDS_LOG2+1:2] (aliases below MMIO)
// Ports:
//   clk   - clock, all state updates on rising edge
//   reset - asynchronous active-high reset, clears all state
//   bus   - data_memory_if.slave (store strobe, address, data, TX byte stream)
// Build option: define DATA_MEMORY_CYCLE_COUNTER_EN to implement the CYCLE
// counter; without it CYCLE reads 0 and no counter flops exist.
module data_memory #(
  parameter int          WORDS_LOG2      = 6,
  parameter logic [31:0] MMIO_BASE       = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH_LOG2 = 2
) (
  input logic          clk,
  input logic          reset,
  data_memory_if.slave bus
);

  localparam int WORDS   = 1 << WORDS_LOG2;
  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W   = FIFO_DEPTH_LOG2 + 1;
  // STATUS layout: bit0 full, bit1 empty, count above them, OVF right after count
  localparam int OVF_BIT = FIFO_DEPTH_LOG2 + 3;

  localparam logic [1:0] REG_CYCLE  = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = 1;
  localparam logic [CNT_W-1:0]           CNT_ONE    = 1;
  localparam logic [CNT_W-1:0]           CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [15:0]                MMIO_UPPER = MMIO_BASE[31:16];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic                  mmio_sel;
  logic                  ram_sel;
  logic                  mmio_mapped;
  logic [1:0]            reg_idx;
  logic [WORDS_LOG2-1:0] word_idx;

  assign mmio_sel    = (bus.addr[31:16] == MMIO_UPPER);
  assign ram_sel     = !mmio_sel;
  assign mmio_mapped = mmio_sel && (bus.addr[15:4] == 12'd0);
  assign reg_idx     = bus.addr[3:2];
  assign word_idx    = bus.addr[WORDS_LOG2+1:2];

  // Byte offset is irrelevant for full-word access
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[1:0];

  logic store_txdata;
  logic store_status;

  assign store_txdata = bus.mem_write && mmio_mapped && (reg_idx == REG_TXDATA);
  assign store_status = bus.mem_write && mmio_mapped && (reg_idx == REG_STATUS);

  // ---------------------------------------------------------------------------
  // Word RAM: flop array so reset can clear every word asynchronously
  // ---------------------------------------------------------------------------
  logic [31:0] ram [WORDS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        ram[i] <= '0;
      end
    end else if (bus.mem_write && ram_sel) begin
      ram[word_idx] <= bus.write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------------
  logic [31:0] cycle_val;

`ifdef DATA_MEMORY_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;

  // Wraps naturally from all-ones to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  // ---------------------------------------------------------------------------
  // TX FIFO: circular buffer, separate occupancy count
  // ---------------------------------------------------------------------------
  logic [7:0]                 fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       ovf;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push;
  logic ovf_set;
  logic ovf_clr;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);
  assign pop        = bus.tx_valid && bus.tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push       = store_txdata && (!fifo_full || pop);
  assign ovf_set    = store_txdata && fifo_full && !pop;
  assign ovf_clr    = store_status && bus.write_data[OVF_BIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.write_data[7:0];
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      // Set has priority over a simultaneous clear
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------------
  logic [31:0] status_word;

  always_comb begin
    status_word                = '0;
    status_word[0]             = fifo_full;
    status_word[1]             = fifo_empty;
    status_word[2 +: CNT_W]    = count;
    status_word[OVF_BIT]       = ovf;
  end

  always_comb begin
    bus.read_data = '0;
    if (ram_sel) begin
      bus.read_data = ram[word_idx];
    end else if (mmio_mapped) begin
      case (reg_idx)
        REG_CYCLE:  bus.read_data = cycle_val;
        REG_STATUS: bus.read_data = status_word;
        default:    bus.read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - scoreboard testbench for data_memory
module tb_data_memory;

  logic clk;
  logic reset;

  data_memory_if bus ();

  data_memory dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        load_q[$];
  logic [7:0]  tx_q[$];
  logic        load_chk;
  int          n_checks;
  int          n_pass;

  logic        hold_pending;
  logic [7:0]  hold_data;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_RSVD   = 32'hFFFF_000C;
  localparam logic [31:0] A_UNMAP  = 32'hFFFF_0010;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.addr       = a;
    bus.write_data = d;
    bus.mem_write  = 1'b1;
    cyc();
    bus.mem_write  = 1'b0;
  endtask

  task automatic expect_load(input logic [31:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.exp          = exp;
    e.name         = name;
    bus.addr       = a;
    bus.mem_write  = 1'b0;
    load_q.push_back(e);
    load_chk       = 1'b1;
    cyc();
    load_chk       = 1'b0;
  endtask

  // Load monitor: compares read_data whenever stimulus marked a load cycle
  always @(negedge clk) begin
    exp_t e;
    if (load_chk) begin
      if (load_q.size() == 0) begin
        chk("load_q_underflow", 32'd1, 32'd0);
      end else begin
        e = load_q.pop_front();
        chk(e.name, bus.read_data, e.exp);
      end
    end
  end

  // TX monitor: byte ordering on handshake, stability while stalled
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("tx_hold_valid", {31'd0, bus.tx_valid}, 32'd1);
        chk("tx_hold_data", {24'd0, bus.tx_data}, {24'd0, hold_data});
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (tx_q.size() == 0) begin
          chk("tx_unexpected_byte", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
        end else begin
          chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, tx_q.pop_front()});
        end
      end
      hold_pending = bus.tx_valid && !bus.tx_ready;
      hold_data    = bus.tx_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    load_chk       = 1'b0;
    hold_pending   = 1'b0;
    hold_data      = '0;
    reset          = 1'b1;
    bus.mem_write  = 1'b0;
    bus.addr       = '0;
    bus.write_data = '0;
    bus.tx_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("reset_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("reset_tx_data", {24'd0, bus.tx_data}, 32'd0);
    expect_load(32'h10, 32'd0, "reset_ram");
    expect_load(A_STATUS, 32'h02, "reset_status");
    expect_load(A_CYCLE, 32'd0, "reset_cycle");

    // RAM store/load, aliasing, read-during-write
    store(32'h10, 32'hDEAD_BEEF);
    expect_load(32'h10, 32'hDEAD_BEEF, "ram_load");
    expect_load(32'h110, 32'hDEAD_BEEF, "ram_alias");
    expect_load(32'h13, 32'hDEAD_BEEF, "ram_byte_offset");
    expect_load(32'h14, 32'd0, "ram_neighbour");
    begin
      exp_t e;
      e.exp          = 32'd0;
      e.name         = "ram_read_during_write";
      bus.addr       = 32'h14;
      bus.write_data = 32'h1234_5678;
      bus.mem_write  = 1'b1;
      load_q.push_back(e);
      load_chk       = 1'b1;
      cyc();
      load_chk       = 1'b0;
      bus.mem_write  = 1'b0;
    end
    expect_load(32'h14, 32'h1234_5678, "ram_after_write");

    // Asynchronous reset between edges clears RAM and FIFO immediately
    store(A_TXDATA, 32'h55);
    chk("push_visible_valid", {31'd0, bus.tx_valid}, 32'd1);
    chk("push_visible_data", {24'd0, bus.tx_data}, 32'h55);
    bus.addr = 32'h10;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_ram", bus.read_data, 32'd0);
    chk("async_rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("async_rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    cyc();
    reset = 1'b0;
    expect_load(A_STATUS, 32'h02, "post_rst_status");

    // Fill FIFO, overflow, OVF clear
    store(A_TXDATA, 32'hAAAA_AA41);
    store(A_TXDATA, 32'h42);
    store(A_TXDATA, 32'h43);
    store(A_TXDATA, 32'h44);
    expect_load(A_STATUS, 32'h11, "status_full");
    store(A_TXDATA, 32'h45);
    expect_load(A_STATUS, 32'h31, "status_ovf");
    store(A_STATUS, 32'h1F);
    expect_load(A_STATUS, 32'h31, "ovf_not_cleared_other_bits");
    store(A_STATUS, 32'h20);
    expect_load(A_STATUS, 32'h11, "ovf_cleared");
    expect_load(A_TXDATA, 32'd0, "txdata_reads_zero");

    // Push + pop on a full FIFO: accepted, no overflow
    tx_q.push_back(8'h41);
    bus.tx_ready = 1'b1;
    store(A_TXDATA, 32'h46);
    bus.tx_ready = 1'b0;
    expect_load(A_STATUS, 32'h11, "full_push_pop");
    cyc();
    cyc();
    tx_q.push_back(8'h42);
    tx_q.push_back(8'h43);
    tx_q.push_back(8'h44);
    tx_q.push_back(8'h46);
    bus.tx_ready = 1'b1;
    repeat (4) cyc();
    bus.tx_ready = 1'b0;
    expect_load(A_STATUS, 32'h02, "drained_status");
    chk("drained_tx_valid", {31'd0, bus.tx_valid}, 32'd0);

    // Push into empty then pop; count steps through 1
    store(A_TXDATA, 32'h77);
    expect_load(A_STATUS, 32'h04, "status_count1");
    tx_q.push_back(8'h77);
    bus.tx_ready = 1'b1;
    cyc();
    bus.tx_ready = 1'b0;
    expect_load(A_STATUS, 32'h02, "status_empty_again");

    // CYCLE register
`ifdef DATA_MEMORY_CYCLE_COUNTER_EN
    begin
      logic [31:0] c0;
      logic [31:0] c1;
      bus.addr = A_CYCLE;
      #1;
      c0 = bus.read_data;
      repeat (5) cyc();
      c1 = bus.read_data;
      chk("cycle_delta5", c1 - c0, 32'd5);
    end
`else
    expect_load(A_CYCLE, 32'd0, "cycle_disabled_a");
    repeat (5) cyc();
    expect_load(A_CYCLE, 32'd0, "cycle_disabled_b");
`endif
    store(A_CYCLE, 32'hFFFF_FFFF);
    expect_load(A_RSVD, 32'd0, "reg_c_reads_zero");

    // Unmapped MMIO: reads 0, stores touch neither RAM nor FIFO
    store(32'h10, 32'h0000_1234);
    store(A_UNMAP, 32'hCAFE_0099);
    store(A_RSVD, 32'h0000_0088);
    expect_load(A_UNMAP, 32'd0, "unmapped_read");
    expect_load(32'h10, 32'h0000_1234, "unmapped_no_ram");
    expect_load(A_STATUS, 32'h02, "unmapped_no_fifo");

    repeat (3) cyc();
    chk("tx_q_drained", tx_q.size(), 32'd0);
    chk("load_q_drained", load_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
Data-side memory stage directly downstream of arm_cpu. It consumes mem_write, alu_result (address) and write_data, and returns read_data combinationally in the same cycle, as the single-cycle core requires.
- Word RAM below MMIO_BASE.
- MMIO page at and above MMIO_BASE: free-running cycle counter, and a 4-entry transmit FIFO drained over a valid/ready byte stream.

Parameters:
WORDS_LOG2, 6, log2 of RAM depth in 32-bit words (64 words default)
MMIO_BASE, 32'hFFFF_0000, first byte address of MMIO page (upper 16 bits decoded)
FIFO_DEPTH_LOG2, 2, log2 of TX FIFO depth (4 entries)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
mem_write  in  1  store strobe from core
addr  in  32  byte address (core alu_result)
write_data  in  32  store data from core
read_data  out  32  load data, combinational from addr
tx_data  out  8  byte at FIFO head
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  consumer accepts byte this cycle

Behaviour:
- One clock (clk). Reset is asynchronous, active-high (reset); its assertion clears all state immediately, regardless of clk.
- Decode:
  - addr[31:16] == MMIO_BASE[31:16] selects MMIO.
  - Otherwise RAM, word index addr[WORDS_LOG2+1:2]. Higher bits and addr[1:0] are ignored, so RAM aliases across the address space below MMIO.
- RAM:
  - Read is combinational.
  - Write is full-word at posedge when mem_write && RAM selected.
  - Reset clears all words to 0.
  - Read-during-write returns old data until the edge.
- MMIO registers, selected by addr[3:2]; addr[15:4] != 0 is unmapped:
  - 0x0 CYCLE (RO):
    - 32-bit counter, +1 every clock; wraps 32'hFFFF_FFFF -> 0.
    - Writes ignored.
    - Reset value 0; first edge after reset release gives 1.
  - 0x4 TXDATA (WO):
    - Store pushes write_data[7:0]; upper bits discarded.
    - Read returns 0.
  - 0x8 STATUS:
    - Read value: bit0 full, bit1 empty, bits[2+FIFO_DEPTH_LOG2:2] count (0..4), next bit (bit5 at default) OVF sticky, other bits 0.
    - Store with write_data bit OVF = 1 clears OVF; other bits ignored.
  - 0xC and unmapped addresses: read 0, writes ignored.
- TX FIFO:
  - Circular buffer with write/read pointers and a separate count; pointers wrap at depth.
  - tx_valid = (count != 0); tx_data = entry at read pointer.
  - Pop when tx_valid && tx_ready.
  - Push when a TXDATA store occurs and (count < depth, or a pop happens in the same cycle).
  - Push and pop together: count unchanged. When full, this is accepted with no overflow.
  - Push when full without a pop: data dropped, count unchanged, OVF set.
  - OVF set and clear in the same cycle: set wins.
  - Pop when empty: impossible by construction (tx_valid = 0).
  - tx_data and tx_valid must hold stable while tx_valid && !tx_ready.
- Reset values: read_data reflects cleared state (RAM = 0, CYCLE = 0), tx_valid = 0, tx_data = 0, count = 0, OVF = 0, pointers = 0.
- Reset mid-operation: FIFO contents discarded, no byte emitted; any in-flight store is lost.
- Latency:
  - Store visible to a load at the same address in the next cycle.
  - Pushed byte appears on tx_data/tx_valid in the next cycle.
  - STATUS reflects the push/pop in the next cycle.

Optional Feature:
Macro DATA_MEMORY_CYCLE_COUNTER_EN.
- Defined: CYCLE counter implemented as above.
- Undefined: no counter flops; CYCLE reads 0; all other behaviour identical.

Test Plan:
- Reset then store 32'hDEADBEEF to addr 0x10, load 0x10 next cycle -> read_data 32'hDEADBEEF. Load 0x110 (alias, WORDS_LOG2 = 6) -> 32'hDEADBEEF. Load 0x14 -> 0.
- Async reset asserted mid-cycle, between edges -> RAM word 0x10 and FIFO cleared immediately; tx_valid 0 before the next edge.
- tx_ready = 0, store 0x41,0x42,0x43,0x44 to 0xFFFF0004 -> STATUS = 0x11 (full, count 4). Fifth store 0x45 -> STATUS = 0x31 (OVF set), 0x45 dropped. Store 0x20 to STATUS -> OVF clear.
- From full, tx_ready = 1 with a simultaneous TXDATA store 0x46 -> no OVF, count stays 4. Drain sequence on tx_data: 0x42,0x43,0x44,0x46 after the 0x41 pop. tx_data stable while tx_ready = 0.
- With counter enabled: read CYCLE at two loads 5 cycles apart -> difference 5. Force counter to 32'hFFFF_FFFF -> next value 0.
- Without DATA_MEMORY_CYCLE_COUNTER_EN: CYCLE reads 0 always. Load 0xFFFF0010 (unmapped) -> 0; store there has no effect on RAM or FIFO.
